// File: rtl/io_output_reg.sv
// -----------------------------------------------------------------------------
// io_output_reg
//
// Memory-mapped output-port block on the CPU store path. It is the store-side
// counterpart of the input-port register block and shares its address window.
// Three 32-bit output ports are written by I/O stores; port 0's low half-word
// is also shown in hex on a 4-digit multiplexed 7-segment display.
//
// Address map (addr[7:2], every other address bit is ignored):
//   6'b110000 : out_port0
//   6'b110001 : out_port1
//   6'b110010 : out_port2
//
// Ports:
//   io_clk          in   1  clock, every state update happens on posedge
//   reset           in   1  synchronous, active-high reset
//   addr            in  32  byte address from the MEM stage
//   datain          in  32  store data from the MEM stage
//   write_io_enable in   1  store-to-I/O qualifier
//   out_port0..2    out 32  output port registers
//   out_update      out  3  bit n pulses for one cycle after port n is written
//   io_read_back    out 32  combinational readback of the port at addr[7:2]
//   seg             out  7  cathodes {g,f,e,d,c,b,a}, active-low, registered
//   an              out  4  digit anodes, active-low, registered
//
// Parameter:
//   SCAN_DIV  width of the display scan counter (legal 2..24). Each digit is
//             held for 2^(SCAN_DIV-2) cycles.
//
// Build option:
//   IO_OUT_READBACK_EN  when defined, io_read_back returns the addressed port.
//                       When undefined, io_read_back is tied to zero and no
//                       readback mux exists.
// -----------------------------------------------------------------------------
module io_output_reg #(
  parameter int SCAN_DIV = 16
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [2:0]  out_update,
  output logic [31:0] io_read_back,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam logic [5:0] ADDR_PORT0 = 6'b110000;
  localparam logic [5:0] ADDR_PORT1 = 6'b110001;
  localparam logic [5:0] ADDR_PORT2 = 6'b110010;

  localparam logic [SCAN_DIV-1:0] SCAN_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

  // Active-low hex digit patterns, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  logic [31:0]         r_port0;
  logic [31:0]         r_port1;
  logic [31:0]         r_port2;
  logic [2:0]          r_update;
  logic [SCAN_DIV-1:0] r_scan;
  logic [3:0]          r_an;
  logic [6:0]          r_seg;

  logic [5:0]          w_word;
  logic                w_wsel0;
  logic                w_wsel1;
  logic                w_wsel2;
  logic [1:0]          w_digit;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg_next;
  logic                w_unused_addr;

  // Only the word offset inside the I/O window is decoded.
  assign w_word        = addr[7:2];
  assign w_unused_addr = ^{addr[31:8], addr[1:0]};

  assign w_wsel0 = write_io_enable & (w_word == ADDR_PORT0);
  assign w_wsel1 = write_io_enable & (w_word == ADDR_PORT1);
  assign w_wsel2 = write_io_enable & (w_word == ADDR_PORT2);

  // The top two scan bits pick the digit, so each digit dwells for
  // 2^(SCAN_DIV-2) cycles.
  assign w_digit = r_scan[SCAN_DIV-1 -: 2];

  always_comb begin
    w_nibble = r_port0[3:0];
    case (w_digit)
      2'd0:    w_nibble = r_port0[3:0];
      2'd1:    w_nibble = r_port0[7:4];
      2'd2:    w_nibble = r_port0[11:8];
      default: w_nibble = r_port0[15:12];
    endcase
  end

  assign w_seg_next = hex7(w_nibble);

  // The display samples the registered port value, so a port0 store reaches
  // seg two cycles after the store cycle. an and seg are both registered from
  // the same digit index, so they always change together with no mixed state.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      r_port0  <= '0;
      r_port1  <= '0;
      r_port2  <= '0;
      r_update <= '0;
      r_scan   <= '0;
      r_an     <= 4'b1111;
      r_seg    <= 7'b1111111;
    end else begin
      if (w_wsel0) r_port0 <= datain;
      if (w_wsel1) r_port1 <= datain;
      if (w_wsel2) r_port2 <= datain;
      r_update <= {w_wsel2, w_wsel1, w_wsel0};
      r_scan   <= r_scan + SCAN_ONE;
      r_an     <= ~(4'b0001 << w_digit);
      r_seg    <= w_seg_next;
    end
  end

  assign out_port0  = r_port0;
  assign out_port1  = r_port1;
  assign out_port2  = r_port2;
  assign out_update = r_update;
  assign an         = r_an;
  assign seg        = r_seg;

`ifdef IO_OUT_READBACK_EN
  logic [31:0] w_read_back;

  always_comb begin
    w_read_back = 32'h0;
    case (w_word)
      ADDR_PORT0: w_read_back = r_port0;
      ADDR_PORT1: w_read_back = r_port1;
      ADDR_PORT2: w_read_back = r_port2;
      default:    w_read_back = 32'h0;
    endcase
  end

  assign io_read_back = w_read_back;
`else
  assign io_read_back = 32'h0;
`endif

endmodule

// File: tb/tb_io_output_reg.sv
module tb_io_output_reg;

  localparam int SCAN_DIV = 4;

  logic        io_clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_enable;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [2:0]  out_update;
  logic [31:0] io_read_back;
  logic [6:0]  seg;
  logic [3:0]  an;

  io_output_reg #(.SCAN_DIV(SCAN_DIV)) dut (
    .io_clk          (io_clk),
    .reset           (reset),
    .addr            (addr),
    .datain          (datain),
    .write_io_enable (write_io_enable),
    .out_port0       (out_port0),
    .out_port1       (out_port1),
    .out_port2       (out_port2),
    .out_update      (out_update),
    .io_read_back    (io_read_back),
    .seg             (seg),
    .an              (an)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  typedef struct {
    int          port;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] m_port [3];
  int          checks = 0;
  int          errors = 0;

  // Digit sequence for out_port0 = 32'h0000A3F0.
  logic [3:0]  exp_an  [4];
  logic [6:0]  exp_seg [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  // Drive one cycle of stimulus, push the expected port write, clock, then
  // pop the scoreboard and compare ports and update pulses.
  task automatic do_cycle(input logic [31:0] a, input logic [31:0] d,
                          input logic en, input logic rst);
    logic [2:0] exp_upd;
    wr_t        e;
    addr            = a;
    datain          = d;
    write_io_enable = en;
    reset           = rst;
    if (!rst && en && a[7:2] >= 6'd48 && a[7:2] <= 6'd50)
      sb.push_back('{int'(a[7:2]) - 48, d});
    tick();
    exp_upd = 3'b000;
    if (rst) begin
      sb.delete();
      m_port[0] = 32'h0;
      m_port[1] = 32'h0;
      m_port[2] = 32'h0;
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      m_port[e.port] = e.data;
      exp_upd[e.port] = 1'b1;
    end
    chk("out_port0", out_port0, m_port[0]);
    chk("out_port1", out_port1, m_port[1]);
    chk("out_port2", out_port2, m_port[2]);
    chk("out_update", 32'(out_update), 32'(exp_upd));
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] ea, input logic [6:0] es);
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  task automatic chk_rb(input logic [31:0] a, input logic [31:0] exp_on);
    addr            = a;
    write_io_enable = 1'b0;
    #1;
`ifdef IO_OUT_READBACK_EN
    chk("io_read_back", io_read_back, exp_on);
`else
    chk("io_read_back", io_read_back, 32'h0);
`endif
  endtask

  initial begin
    exp_an[0]  = 4'b1110; exp_seg[0] = 7'b1000000;
    exp_an[1]  = 4'b1101; exp_seg[1] = 7'b0001110;
    exp_an[2]  = 4'b1011; exp_seg[2] = 7'b0110000;
    exp_an[3]  = 4'b0111; exp_seg[3] = 7'b0001000;
    m_port[0] = 32'h0;
    m_port[1] = 32'h0;
    m_port[2] = 32'h0;
    reset           = 1'b1;
    addr            = 32'h0;
    datain          = 32'h0;
    write_io_enable = 1'b0;

    // Reset for two cycles, then release.
    do_cycle(32'h0, 32'h0, 1'b0, 1'b1);
    do_cycle(32'h0, 32'h0, 1'b0, 1'b1);
    reset = 1'b0;
    chk_disp("reset", 4'b1111, 7'b1111111);
    do_cycle(32'h0, 32'h0, 1'b0, 1'b0);
    chk_disp("first_digit", 4'b1110, 7'b1000000);

    // Writes to the three ports on consecutive cycles.
    do_cycle(32'h000000C0, 32'h12345678, 1'b1, 1'b0);
    do_cycle(32'h000000C4, 32'hDEADBEEF, 1'b1, 1'b0);
    do_cycle(32'h000000C8, 32'h00000001, 1'b1, 1'b0);
    do_cycle(32'h0, 32'h0, 1'b0, 1'b0);
    chk_rb(32'h000000C4, 32'hDEADBEEF);
    chk_rb(32'h000000C0, 32'h12345678);
    chk_rb(32'h000000C8, 32'h00000001);

    // Back-to-back writes to one port, including a repeated value.
    do_cycle(32'h000000C8, 32'h000000AA, 1'b1, 1'b0);
    do_cycle(32'h000000C8, 32'h000000BB, 1'b1, 1'b0);
    do_cycle(32'h000000C8, 32'h000000BB, 1'b1, 1'b0);
    do_cycle(32'h0, 32'h0, 1'b0, 1'b0);

    // Ignored writes: out-of-window word, enable low, neighbouring word.
    do_cycle(32'h000000CC, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_cycle(32'h000000C0, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_cycle(32'h000000BC, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk_rb(32'h000000CC, 32'h0);

    // Upper and lowest address bits are ignored by the decode.
    do_cycle(32'hABCDEFC5, 32'h0BADF00D, 1'b1, 1'b0);
    chk_rb(32'hFFFFFFC7, 32'h0BADF00D);

    // Scan sequence aligned by a reset, port0 = 32'h0000A3F0.
    do_cycle(32'h0, 32'h0, 1'b0, 1'b1);
    chk_disp("scan_reset", 4'b1111, 7'b1111111);
    do_cycle(32'h000000C0, 32'h0000A3F0, 1'b1, 1'b0);
    chk_disp("scan_k1", exp_an[0], exp_seg[0]);
    for (int k = 2; k <= 17; k++) begin
      do_cycle(32'h0, 32'h0, 1'b0, 1'b0);
      chk_disp($sformatf("scan_k%0d", k), exp_an[((k - 1) / 4) % 4], exp_seg[((k - 1) / 4) % 4]);
    end

    // Port0 store while digit 0 is showing reaches seg two cycles later.
    do_cycle(32'h000000C0, 32'h0000A3F5, 1'b1, 1'b0);
    chk_disp("live_k18", 4'b1110, 7'b1000000);
    do_cycle(32'h0, 32'h0, 1'b0, 1'b0);
    chk_disp("live_k19", 4'b1110, 7'b0010010);

    // Reset in the same cycle as a port1 write.
    do_cycle(32'h000000C4, 32'h00000077, 1'b1, 1'b0);
    do_cycle(32'h000000C4, 32'h00000055, 1'b1, 1'b1);
    chk_disp("midrst", 4'b1111, 7'b1111111);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      do_cycle(32'h0, 32'h0, 1'b0, 1'b0);
      chk_disp($sformatf("rst_scan_k%0d", k), exp_an[(k - 1) / 4], 7'b1000000);
    end
    chk_rb(32'h000000C4, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_output_reg.md
Name: io_output_reg

Overview:
- Memory-mapped output-port block for the pipelined CPU, and the store-side counterpart of the input-port register block.
- The CPU store path writes 32-bit values to three output ports at the same address window as the inputs (addr[7:2] = 6'b110000..6'b110010).
- Also drives a 4-digit multiplexed 7-segment display showing out_port0[15:0] in hex.
- Sits between the MEM stage I/O select logic and the board pins.

Parameters:
- SCAN_DIV, 16: width of the display scan counter. Each digit is held for 2^(SCAN_DIV-2) cycles. Legal range is 2..24; use 4 in simulation.

Ports:
- io_clk  input  1  system/IO clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- addr  input  32  byte address from MEM stage; only addr[7:2] is decoded
- datain  input  32  store data from MEM stage
- write_io_enable  input  1  store-to-I/O qualifier from the CPU
- out_port0  output  32  output port 0 register
- out_port1  output  32  output port 1 register
- out_port2  output  32  output port 2 register
- out_update  output  3  one-cycle pulse; bit n set in the cycle after port n is written
- io_read_back  output  32  combinational readback of the port selected by addr[7:2]
- seg  output  7  7-segment cathodes {g,f,e,d,c,b,a}, active-low, registered
- an  output  4  digit anodes, active-low, registered

Behaviour:
- Reset (reset=1 at posedge):
  - out_port0/1/2 = 0, out_update = 0.
  - Scan counter = 0.
  - an = 4'b1111 (all digits off), seg = 7'b1111111.
  - Reset overrides any write in the same cycle.
- Write decode:
  - wsel0 = write_io_enable & (addr[7:2]==6'b110000).
  - wsel1 = write_io_enable & (addr[7:2]==6'b110001).
  - wsel2 = write_io_enable & (addr[7:2]==6'b110010).
  - All other addr[7:2] values are ignored (no port change, no pulse).
  - addr[31:8] and addr[1:0] are don't-care.
- Write timing:
  - On posedge with wselN=1, out_portN <= datain (full 32 bits).
  - The new value is visible one cycle after the store cycle.
  - Back-to-back writes to the same port take the last value.
- out_update:
  - Registered: out_update[n] <= wselN every cycle.
  - Each pulse lasts exactly 1 cycle per write.
  - Consecutive-cycle writes hold the bit high for consecutive cycles.
  - Writing the same value still pulses.
- io_read_back is combinational:
  - 6'b110000 gives out_port0, 6'b110001 gives out_port1, 6'b110010 gives out_port2, all others give 32'h0.
  - No latch inference.
- Scan counter:
  - SCAN_DIV-bit counter, increments every cycle, wraps from all-ones to 0.
  - Digit index d = counter[SCAN_DIV-1:SCAN_DIV-2].
- Display registers, updated each posedge from the current d (one-cycle latency):
  - an <= ~(4'b0001 << d).
  - seg <= hex7(out_port0[4d+3:4d]).
  - hex7 is the active-low standard map: 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, 4 = 7'b0011001, 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000, 8 = 7'b0000000, 9 = 7'b0010000, A = 7'b0001000, b = 7'b0000011, C = 7'b1000110, d = 7'b0100001, E = 7'b0000110, F = 7'b0001110.
- A write to port0 while its digit is being shown appears on seg at the posedge after out_port0 updates, i.e. 2 cycles after the store cycle. No glitch state is allowed.

Optional Feature:
- Macro: IO_OUT_READBACK_EN.
- Defined: io_read_back behaves as described above, so software can read back its output ports.
- Undefined: io_read_back is constant 32'h0 and no readback mux is synthesized. All other behaviour is unchanged.

Test Plan:
- Reset: assert reset 2 cycles, then release -> ports = 0, out_update = 3'b000, an = 4'b1111, seg = 7'b1111111. After 1 more cycle, an = 4'b1110 and seg = 7'b1000000.
- Port writes: addr = 32'h000000C0 / C4 / C8, datain = 32'h12345678 / 32'hDEADBEEF / 32'h1, write_io_enable = 1 on consecutive cycles -> each port updates the cycle after its write. out_update shows 001, 010, 100 on successive cycles. With the macro defined, io_read_back at addr C4 = 32'hDEADBEEF.
- Ignored writes: addr = 32'h000000CC with enable = 1, and addr = 32'h000000C0 with enable = 0 -> no port change, out_update = 0. io_read_back at CC = 0.
- Scan (SCAN_DIV=4), out_port0 = 32'h0000A3F0: an cycles 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110. seg shows 1000000 (0), 0001110 (F), 0110000 (3), 0001000 (A) in step.
- Reset mid-operation: reset asserted in the same cycle as a write of 32'h55 to port1 -> out_port1 = 0 and out_update = 0 next cycle. The scan counter restarts at digit 0.
- Macro undefined: the write from the port-write scenario followed by a read at C0 -> io_read_back = 0, while out_port0 = 32'h12345678.
